// File: rtl/mux_pkg.sv
// Shared defaults and helpers for the mux_2to1 slice.
package mux_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 8;

  // All-ones value of a w-bit counter; the select-change counter stops here.
  function automatic int unsigned sat_max(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/mux_2to1_if.sv
// Data/select bundle of the 2:1 mux plus its registered side-band outputs.
interface mux_2to1_if
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
);
  logic [WIDTH-1:0] w0;
  logic [WIDTH-1:0] w1;
  logic             s;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] f_q;
  logic             s_q;
  logic             sel_edge;
  logic [CNT_W-1:0] sel_changes;

  // Driver side: supplies data and select, observes results.
  modport master (
    output w0, w1, s,
    input  f, f_q, s_q, sel_edge, sel_changes
  );

  // Mux side.
  modport slave (
    input  w0, w1, s,
    output f, f_q, s_q, sel_edge, sel_changes
  );
endinterface

// File: rtl/mux2_core.sv
// Pure combinational WIDTH-bit 2:1 selector.
module mux2_core
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] w0,
  input  logic [WIDTH-1:0] w1,
  input  logic             s,
  output logic [WIDTH-1:0] f
);

  // Plain ?: so an unknown select propagates the simulator's usual way.
  assign f = s ? w1 : w0;

endmodule

// File: rtl/mux_2to1.sv
// 2:1 mux with zero-latency output, registered copy and select-change tracking.
module mux_2to1
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic      clk,
  input  logic      rst,
  mux_2to1_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] fr_d, fr_q;
  logic             sr_d, sr_q;
  logic             edge_d, edge_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  mux2_core #(.WIDTH(WIDTH)) u_core (
    .w0 (bus.w0),
    .w1 (bus.w1),
    .s  (bus.s),
    .f  (f)
  );

  // Next-state for the side-band registers; counter saturates instead of wrapping.
  always_comb begin
    fr_d   = f;
    sr_d   = bus.s;
    edge_d = (bus.s != sr_q);
    cnt_d  = cnt_q;
    if (edge_d && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Side-band registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      fr_q   <= '0;
      sr_q   <= 1'b0;
      edge_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      fr_q   <= fr_d;
      sr_q   <= sr_d;
      edge_q <= edge_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.f           = f;
  assign bus.f_q         = fr_q;
  assign bus.s_q         = sr_q;
  assign bus.sel_edge    = edge_q;
  assign bus.sel_changes = cnt_q;

endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1: directed scenarios plus a randomized run.
module tb_mux_2to1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // A: narrow, 8-bit counter. B: narrow, 2-bit counter. C: byte wide.
  mux_2to1_if #(.WIDTH(1), .CNT_W(8)) ia ();
  mux_2to1_if #(.WIDTH(1), .CNT_W(2)) ib ();
  mux_2to1_if #(.WIDTH(8), .CNT_W(8)) ic ();

  mux_2to1 #(.WIDTH(1), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  mux_2to1 #(.WIDTH(1), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  mux_2to1 #(.WIDTH(8), .CNT_W(8)) dut_c (.clk(clk), .rst(rst), .bus(ic));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ia.s = 1'b0; ib.s = 1'b0; ic.s = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    ia.w0 = 1'b0; ia.w1 = 1'b1; ia.s = 1'b1;
    ib.w0 = 1'b0; ib.w1 = 1'b0; ib.s = 1'b1;
    ic.w0 = 8'h00; ic.w1 = 8'hFF; ic.s = 1'b1;
    rst = 1'b1;
    tick();
    n_cmp++; if (ia.f_q !== 1'b0) begin n_err++; $display("FAIL reset_a_fq got %b want 0", ia.f_q); end
    n_cmp++; if (ia.s_q !== 1'b0) begin n_err++; $display("FAIL reset_a_sq got %b want 0", ia.s_q); end
    n_cmp++; if (ia.sel_edge !== 1'b0) begin n_err++; $display("FAIL reset_a_edge got %b want 0", ia.sel_edge); end
    n_cmp++; if (ia.sel_changes !== 8'd0) begin n_err++; $display("FAIL reset_a_cnt got %0d want 0", ia.sel_changes); end
    n_cmp++; if (ib.sel_changes !== 2'd0) begin n_err++; $display("FAIL reset_b_cnt got %0d want 0", ib.sel_changes); end
    n_cmp++; if (ic.f_q !== 8'h00) begin n_err++; $display("FAIL reset_c_fq got %h want 00", ic.f_q); end
    n_cmp++; if (ia.f !== 1'b1) begin n_err++; $display("FAIL reset_a_f_comb got %b want 1", ia.f); end
    n_cmp++; if (ic.f !== 8'hFF) begin n_err++; $display("FAIL reset_c_f_comb got %h want ff", ic.f); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_truth_table();
    logic [2:0] pat [9];
    logic       exp [9];
    pat = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b110, 3'b111};
    exp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 9; i++) begin
      {ia.s, ia.w1, ia.w0} = pat[i];
      #1;
      n_cmp++;
      if (ia.f !== exp[i]) begin
        n_err++; $display("FAIL truth_%0d swx=%b got %b want %b", i, pat[i], ia.f, exp[i]);
      end
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    ia.s = 1'b1; ia.w1 = 1'b1; ia.w0 = 1'b0;
    #1;
    n_cmp++; if (ia.f !== 1'b1) begin n_err++; $display("FAIL reg_f got %b want 1", ia.f); end
    tick();
    n_cmp++; if (ia.f_q !== 1'b1) begin n_err++; $display("FAIL reg_fq got %b want 1", ia.f_q); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    n_cmp++; if (ia.f_q !== 1'b0) begin n_err++; $display("FAIL reg_rst_fq got %b want 0", ia.f_q); end
    n_cmp++; if (ia.s_q !== 1'b0) begin n_err++; $display("FAIL reg_rst_sq got %b want 0", ia.s_q); end
    n_cmp++; if (ia.f !== 1'b1) begin n_err++; $display("FAIL reg_rst_f got %b want 1", ia.f); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_select_edges();
    logic   sseq [5];
    logic   eedge [5];
    int     ecnt [5];
    sseq  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    eedge = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    ecnt  = '{0, 1, 1, 2, 3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ia.s = sseq[i];
      tick();
      n_cmp++;
      if (ia.sel_edge !== eedge[i]) begin
        n_err++; $display("FAIL sel_edge_%0d got %b want %b", i, ia.sel_edge, eedge[i]);
      end
      n_cmp++;
      if (ia.sel_changes !== 8'(ecnt[i])) begin
        n_err++; $display("FAIL sel_changes_%0d got %0d want %0d", i, ia.sel_changes, ecnt[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    int ecnt [6];
    ecnt = '{1, 2, 3, 3, 3, 3};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ib.s = ~ib.s;
      tick();
      n_cmp++;
      if (ib.sel_changes !== 2'(ecnt[i])) begin
        n_err++; $display("FAIL sat_%0d got %0d want %0d", i, ib.sel_changes, ecnt[i]);
      end
      n_cmp++;
      if (ib.sel_edge !== 1'b1) begin
        n_err++; $display("FAIL sat_edge_%0d got %b want 1", i, ib.sel_edge);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_width();
    do_reset();
    ic.w0 = 8'hA5; ic.w1 = 8'h3C; ic.s = 1'b0;
    #1;
    n_cmp++; if (ic.f !== 8'hA5) begin n_err++; $display("FAIL width_f0 got %h want a5", ic.f); end
    tick();
    n_cmp++; if (ic.f_q !== 8'hA5) begin n_err++; $display("FAIL width_fq0 got %h want a5", ic.f_q); end
    @(negedge clk);
    ic.s = 1'b1;
    #1;
    n_cmp++; if (ic.f !== 8'h3C) begin n_err++; $display("FAIL width_f1 got %h want 3c", ic.f); end
    n_cmp++; if (ic.f_q !== 8'hA5) begin n_err++; $display("FAIL width_fq_hold got %h want a5", ic.f_q); end
    tick();
    n_cmp++; if (ic.f_q !== 8'h3C) begin n_err++; $display("FAIL width_fq1 got %h want 3c", ic.f_q); end
  endtask

  // Reference: last sampled select, change counts clamped at their ceilings.
  task automatic test_random();
    logic       m_s;
    int         m_cc, m_cb;
    logic [7:0] e_fq, e_fc;
    logic       e_edge, e_fb;
    do_reset();
    m_s = 1'b0; m_cc = 0; m_cb = 0;
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 24) == 0);
      ic.s  = 1'($urandom_range(0, 1));
      ib.s  = ic.s;
      ic.w0 = 8'($urandom);
      ic.w1 = 8'($urandom);
      ib.w0 = 1'($urandom);
      ib.w1 = 1'($urandom);
      #1;
      e_fc = (ic.s == 1'b1) ? ic.w1 : ic.w0;
      e_fb = (ib.s == 1'b1) ? ib.w1 : ib.w0;
      n_cmp++; if (ic.f !== e_fc) begin n_err++; $display("FAIL rnd_c_f[%0d] got %h want %h", n, ic.f, e_fc); end
      n_cmp++; if (ib.f !== e_fb) begin n_err++; $display("FAIL rnd_b_f[%0d] got %b want %b", n, ib.f, e_fb); end
      if (rst) begin
        m_s = 1'b0; m_cc = 0; m_cb = 0; e_edge = 1'b0; e_fq = 8'h00;
      end else begin
        e_edge = (ic.s != m_s);
        if (e_edge) begin
          m_cc = (m_cc + 1 > 255) ? 255 : m_cc + 1;
          m_cb = (m_cb + 1 > 3) ? 3 : m_cb + 1;
        end
        m_s  = ic.s;
        e_fq = e_fc;
      end
      tick();
      n_cmp++; if (ic.f_q !== e_fq) begin n_err++; $display("FAIL rnd_c_fq[%0d] got %h want %h", n, ic.f_q, e_fq); end
      n_cmp++; if (ic.s_q !== m_s) begin n_err++; $display("FAIL rnd_c_sq[%0d] got %b want %b", n, ic.s_q, m_s); end
      n_cmp++; if (ic.sel_edge !== e_edge) begin n_err++; $display("FAIL rnd_c_edge[%0d] got %b want %b", n, ic.sel_edge, e_edge); end
      n_cmp++; if (ic.sel_changes !== 8'(m_cc)) begin n_err++; $display("FAIL rnd_c_cnt[%0d] got %0d want %0d", n, ic.sel_changes, m_cc); end
      n_cmp++; if (ib.sel_changes !== 2'(m_cb)) begin n_err++; $display("FAIL rnd_b_cnt[%0d] got %0d want %0d", n, ib.sel_changes, m_cb); end
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  initial begin
    ia.w0 = '0; ia.w1 = '0; ia.s = 1'b0;
    ib.w0 = '0; ib.w1 = '0; ib.s = 1'b0;
    ic.w0 = '0; ic.w1 = '0; ic.s = 1'b0;
    test_reset();
    test_truth_table();
    test_registered();
    test_select_edges();
    test_saturation();
    test_width();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
